// File: rtl/dot_product_accumulator_pkg.sv
// Shared widths, FSM encoding and the full-adder cell
// used by the dot-product accumulator.
package dot_product_accumulator_pkg;

  localparam int PROD_W = 12;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // {carry, sum} of one full-adder cell
  function automatic logic [1:0] full_add(
    input logic a,
    input logic b,
    input logic ci
  );
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/dot_product_accumulator_adder.sv
// Ripple-carry adder built from full-adder cells, carry-in tied low.
// W defaults to the accumulator width; the carry out feeds the overflow flag.
module adder_16bit
  import dot_product_accumulator_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    for (int i = 0; i < W; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
    cout = c[W];
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums N_TERMS unsigned products, then holds the result
// until the consumer takes it.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 prod_valid,
  input  logic [PROD_W-1:0]    prod,
  output logic                 prod_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cout;
  logic                 take;

  // a restart request blocks the product offered alongside it
  assign prod_ready = (state_q == ACCUM) && !start;
  assign take       = prod_ready && prod_valid;

  adder_16bit #(.W(ACC_WIDTH)) u_add (
    .a    (acc_q),
    .b    (ACC_WIDTH'(prod)),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (take) begin
          acc_d = sum;
          ovf_d = ovf_q | cout;
          cnt_d = cnt_q + ONE;
          if (cnt_d == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out   = acc_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench: three builds (4 terms, 15 terms, 15 terms on a 14-bit sum)
// driven by vector tables, directed sequences and a random run.
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b0;
  logic [2:0]  st = '0;
  logic [2:0]  pv = '0;
  logic [2:0]  ordy = '0;
  logic [11:0] pd [3];
  logic        pr0, pr1, pr2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [15:0] acc0, acc1;
  logic [13:0] acc2;
  int          checks = 0;
  int          errors = 0;

  always #5 if (clk_en) clk = ~clk;

  dot_product_accumulator #(.N_TERMS(4)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .prod_valid(pv[0]),
    .prod(pd[0]), .prod_ready(pr0), .acc_out(acc0), .ovf(of0),
    .out_valid(ov0), .out_ready(ordy[0])
  );

  dot_product_accumulator #(.N_TERMS(15)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .prod_valid(pv[1]),
    .prod(pd[1]), .prod_ready(pr1), .acc_out(acc1), .ovf(of1),
    .out_valid(ov1), .out_ready(ordy[1])
  );

  dot_product_accumulator #(.N_TERMS(15), .ACC_WIDTH(14)) dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .prod_valid(pv[2]),
    .prod(pd[2]), .prod_ready(pr2), .acc_out(acc2), .ovf(of2),
    .out_valid(ov2), .out_ready(ordy[2])
  );

  function automatic logic [31:0] g_acc(int d);
    case (d)
      0: return 32'(acc0);
      1: return 32'(acc1);
      default: return 32'(acc2);
    endcase
  endfunction

  function automatic logic g_rdy(int d);
    case (d)
      0: return pr0;
      1: return pr1;
      default: return pr2;
    endcase
  endfunction

  function automatic logic g_vld(int d);
    case (d)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic g_ovf(int d);
    case (d)
      0: return of0;
      1: return of1;
      default: return of2;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int d);
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
  endtask

  task automatic send(int d, int v, int gap);
    repeat (gap) tick();
    pv[d] = 1'b1;
    pd[d] = 12'(v);
    @(negedge clk);
    chk("send_ready", 32'(g_rdy(d)), 1);
    tick();
    pv[d] = 1'b0;
  endtask

  typedef struct {
    int p[4];
    int g[4];
    int hold;
    int acc;
  } vec_t;

  function automatic vec_t mk(int p0, int p1, int p2, int p3,
                              int g0, int g1, int g2, int g3,
                              int hold, int acc);
    vec_t v;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
    v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3;
    v.hold = hold;
    v.acc  = acc;
    return v;
  endfunction

  vec_t tbl [4];

  initial begin
    int mode;
    int sum;
    int n;

    tbl[0] = mk(3969, 3969, 3969, 3969, 0, 0, 0, 0, 0, 15876);
    tbl[1] = mk(10, 20, 30, 40, 0, 1, 3, 2, 5, 100);
    tbl[2] = mk(4095, 4095, 4095, 4095, 1, 0, 2, 0, 2, 16380);
    tbl[3] = mk(0, 1, 0, 4094, 0, 0, 0, 0, 1, 4095);
    for (int i = 0; i < 3; i++) pd[i] = '0;

    #1 rst = 1'b1;
    #11;
    chk("rst_ready", 32'(pr0), 0);
    chk("rst_valid", 32'(ov0), 0);
    chk("rst_acc", 32'(acc0), 0);
    chk("rst_ovf", 32'(of0), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_ready", 32'(pr0), 0);
    tick();

    for (int t = 0; t < 4; t++) begin
      ordy[0] = (tbl[t].hold == 0);
      go(0);
      for (int k = 0; k < 4; k++) send(0, tbl[t].p[k], tbl[t].g[k]);
      for (int h = 0; h < tbl[t].hold; h++) begin
        st[0] = 1'b1;
        pv[0] = 1'b1;
        pd[0] = 12'hfff;
        @(negedge clk);
        chk("hold_valid", 32'(ov0), 1);
        chk("hold_ready", 32'(pr0), 0);
        chk("hold_acc", 32'(acc0), 32'(tbl[t].acc));
        tick();
      end
      st[0] = 1'b0;
      pv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      chk("res_valid", 32'(ov0), 1);
      chk("res_acc", 32'(acc0), 32'(tbl[t].acc));
      chk("res_ovf", 32'(of0), 0);
      tick();
      ordy[0] = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(ov0), 0);
      chk("idle_acc", 32'(acc0), 32'(tbl[t].acc));
      chk("idle_ready", 32'(pr0), 0);
      tick();
    end

    go(0);
    send(0, 5, 0);
    send(0, 7, 0);
    st[0] = 1'b1;
    pv[0] = 1'b1;
    pd[0] = 12'd100;
    @(negedge clk);
    chk("restart_ready", 32'(pr0), 0);
    chk("pre_restart_acc", 32'(acc0), 12);
    tick();
    st[0] = 1'b0;
    pv[0] = 1'b0;
    @(negedge clk);
    chk("restart_acc", 32'(acc0), 0);
    chk("restart_accum", 32'(pr0), 1);
    tick();
    for (int k = 1; k <= 4; k++) send(0, k, 0);
    @(negedge clk);
    chk("restart_valid", 32'(ov0), 1);
    chk("restart_sum", 32'(acc0), 10);
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;

    go(1);
    for (int k = 0; k < 15; k++) send(1, 4095, k % 2);
    @(negedge clk);
    chk("n15_valid", 32'(ov1), 1);
    chk("n15_acc", 32'(acc1), 61425);
    chk("n15_ovf", 32'(of1), 0);
    tick();

    ordy[2] = 1'b1;
    go(2);
    for (int k = 0; k < 15; k++) send(2, 4095, 0);
    @(negedge clk);
    chk("w14_valid", 32'(ov2), 1);
    chk("w14_acc", 32'(acc2), 12273);
    chk("w14_ovf", 32'(of2), 1);
    tick();
    ordy[2] = 1'b0;
    @(negedge clk);
    chk("w14_idle_ovf", 32'(of2), 1);
    tick();
    go(2);
    @(negedge clk);
    chk("w14_clr_ovf", 32'(of2), 0);
    chk("w14_clr_acc", 32'(acc2), 0);
    tick();
    send(2, 300, 0);

    go(0);
    send(0, 9, 0);
    send(0, 11, 0);
    clk_en = 1'b0;
    #7 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("arst_ready", 32'(g_rdy(d)), 0);
      chk("arst_valid", 32'(g_vld(d)), 0);
      chk("arst_acc", g_acc(d), 0);
      chk("arst_ovf", 32'(g_ovf(d)), 0);
    end
    #5 rst = 1'b0;
    #3 clk_en = 1'b1;
    tick();
    pv = 3'b111;
    pd[0] = 12'd50;
    pd[1] = 12'd50;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(pr0), 0);
      chk("post_rst_acc", 32'(acc0), 0);
      chk("post_rst_hold", 32'(ov1), 0);
      tick();
    end
    pv = '0;

    mode = 0;
    sum  = 0;
    n    = 0;
    for (int c = 0; c < 400; c++) begin
      st[0]   = ($urandom_range(0, 9) == 0);
      pv[0]   = ($urandom_range(0, 9) < 6);
      pd[0]   = 12'($urandom_range(0, 4095));
      ordy[0] = ($urandom_range(0, 9) < 4);
      @(negedge clk);
      chk("rnd_ready", 32'(pr0), 32'(mode == 1 && !st[0]));
      chk("rnd_valid", 32'(ov0), 32'(mode == 2));
      chk("rnd_acc", 32'(acc0), sum % 65536);
      chk("rnd_ovf", 32'(of0), 32'(sum > 65535));
      if (mode == 0) begin
        if (st[0]) begin
          mode = 1;
          sum  = 0;
          n    = 0;
        end
      end else if (mode == 1) begin
        if (st[0]) begin
          sum = 0;
          n   = 0;
        end else if (pv[0]) begin
          sum += int'(pd[0]);
          n++;
          if (n == 4) mode = 2;
        end
      end else if (ordy[0]) begin
        mode = 0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 Parameter N_TERMS SHALL be declared with default 4, giving the number of products summed per result, legal range 1..15.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 Port start  input  1  SHALL be a one-cycle request to clear the sum and begin a new accumulation.
REQ-005 Port prod_valid  input  1  SHALL mark that prod holds a finished product from the upstream multiplier.
REQ-006 Port prod  input  12  SHALL be the unsigned 12-bit product (6x6 multiplier result).
REQ-007 Port prod_ready  output  1  SHALL mark that the block accepts prod this cycle.
REQ-008 Port acc_out  output  16  SHALL be the unsigned accumulated sum.
REQ-009 Port ovf  output  1  SHALL be a sticky flag for a carry out of bit 15 during the current accumulation.
REQ-010 Port out_valid  output  1  SHALL mark that acc_out/ovf hold a completed result.
REQ-011 Port out_ready  input  1  SHALL mark that the downstream consumer takes the result this cycle.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, ACCUM, HOLD, with IDLE as the reset state.
REQ-013 In IDLE: prod_ready=0, out_valid=0; start=1 -> ACCUM, with acc_out=0, ovf=0, term count=0 on that edge.
REQ-014 In ACCUM: prod_ready=1 except when start=1, in which case prod_ready=0.
REQ-015 A transfer SHALL occur only on a cycle with prod_valid=1 and prod_ready=1; acc_out SHALL equal old acc_out + zero-extended prod on the following edge (one-cycle latency).
REQ-016 Addition SHALL wrap modulo 2^16; a carry out of bit 15 SHALL set ovf, which stays set until the next start or rst.
REQ-017 The transfer that makes the term count equal N_TERMS SHALL move the FSM to HOLD on that same edge.
REQ-018 prod_valid=0 in ACCUM SHALL leave all state unchanged (stall of any length).
REQ-019 start=1 in ACCUM SHALL restart: acc_out=0, ovf=0, count=0, remain in ACCUM; the concurrent product SHALL NOT be accepted.
REQ-020 In HOLD: out_valid=1, prod_ready=0, acc_out/ovf held stable until out_ready=1.
REQ-021 out_valid=1 and out_ready=1 SHALL return the FSM to IDLE on that edge; acc_out/ovf SHALL keep their values in IDLE.
REQ-022 start=1 in HOLD SHALL be ignored; an unconsumed result is never discarded.
REQ-023 The term counter SHALL be 4 bits wide and SHALL NOT wrap within one accumulation.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, acc_out=0, ovf=0, count=0, prod_ready=0, out_valid=0, regardless of clk.
REQ-025 rst asserted mid-accumulation or in HOLD SHALL discard the partial or pending result; after deassertion the block waits for start.

Structure
REQ-026 Constants PROD_W=12, ACC_W=16, CNT_W=4 and the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) SHALL live in the shared package.
REQ-027 The 16-bit sum and carry SHALL come from one sub-module, adder_16bit (ripple of full-adder cells, cin tied 0), instantiated once; no '+' on the datapath.

Verification
REQ-028 rst pulse mid-cycle with clk stopped -> all outputs 0 immediately; FSM in IDLE.
REQ-029 N_TERMS=4, start, then prod 12'd3969 x4 back-to-back with out_ready=1 -> out_valid one cycle after 4th transfer, acc_out=16'd15876, ovf=0, then IDLE.
REQ-030 Products 10,20,30,40 with prod_valid gaps of 0-3 cycles and out_ready held 0 for 5 cycles -> acc_out=16'd100 stable, out_valid=1 throughout hold, prod_ready=0 in HOLD.
REQ-031 N_TERMS=15, fifteen products of 12'd4095 -> acc_out=16'd61425, ovf=0; N_TERMS=15 with sum forced past 65535 (preload via 15x4095 then extra run w/o start is not possible, so use a bench build with ACC_W override 14) -> ovf=1, acc_out=wrapped value.
REQ-032 start after two transfers (5,7) then products 1,2,3,4 -> acc_out=16'd10; product presented with start not accepted (prod_ready=0).
REQ-033 start asserted in HOLD with out_ready=0 -> ignored, acc_out unchanged; then out_ready=1 -> IDLE.
